// File: rtl/tcam_pkg.sv
// Shared definitions for the TCAM rule-update path: sizing helpers,
// the default chunk width and the update sequencer state encoding.
package tcam_pkg;

    localparam int CHUNK_W_DEF = 5;

    // Ceiling log2, never below 1 so that index ports keep a real width
    function automatic int log2c(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int num_chunk(input int rule_len, input int chunk_w);
        return (rule_len + chunk_w - 1) / chunk_w;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/tcam_wbit_gen.sv
// Combinational write-bit generator: for one LUTRAM address, decides per
// chunk whether the rule's (value, mask) slice matches that address.
module tcam_wbit_gen
    import tcam_pkg::*;
#(
    parameter int RULE_LEN = 32,
    parameter int CHUNK_W  = CHUNK_W_DEF,
    localparam int NUM_CHUNK = num_chunk(RULE_LEN, CHUNK_W)
) (
    input  logic [CHUNK_W-1:0]   addr,
    input  logic [RULE_LEN-1:0]  value,
    input  logic [RULE_LEN-1:0]  mask,
    input  logic                 op,
    output logic [NUM_CHUNK-1:0] wbit
);

    localparam int PAD_W = NUM_CHUNK * CHUNK_W;

    logic [PAD_W-1:0] value_pad;
    logic [PAD_W-1:0] mask_pad;

    // Zero extension makes the unused top bits of the last chunk don't-care
    assign value_pad = PAD_W'(value);
    assign mask_pad  = PAD_W'(mask);

    always_comb begin
        wbit = '0;
        for (int c = 0; c < NUM_CHUNK; c++) begin
            wbit[c] = op & (((addr ^ value_pad[c*CHUNK_W +: CHUNK_W])
                             & mask_pad[c*CHUNK_W +: CHUNK_W]) == '0);
        end
    end

endmodule

// File: rtl/tcam_update_ctrl.sv
// Rule-update sequencer: takes one install/delete command, stalls search,
// and rewrites the rule column at every chunk RAM address in turn.
module tcam_update_ctrl
    import tcam_pkg::*;
#(
    parameter int RULE_LEN = 32,
    parameter int MAX_RULE = 64,
    parameter int CHUNK_W  = CHUNK_W_DEF,
    localparam int IDX_W     = log2c(MAX_RULE),
    localparam int NUM_CHUNK = num_chunk(RULE_LEN, CHUNK_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 upd_valid,
    output logic                 upd_ready,
    input  logic                 upd_op,
    input  logic [IDX_W-1:0]     upd_rule_idx,
    input  logic [RULE_LEN-1:0]  upd_value,
    input  logic [RULE_LEN-1:0]  upd_mask,
    output logic                 ram_we,
    output logic [CHUNK_W-1:0]   ram_addr,
    output logic [IDX_W-1:0]     ram_rule_idx,
    output logic [NUM_CHUNK-1:0] ram_wbit,
    output logic                 search_stall,
    output logic                 done,
    output logic                 err
);

    state_e state_q, state_d;

    logic                 op_q;
    logic [IDX_W-1:0]     idx_q;
    logic [RULE_LEN-1:0]  value_q;
    logic [RULE_LEN-1:0]  mask_q;

    logic                 ram_we_q, ram_we_d;
    logic [CHUNK_W-1:0]   ram_addr_q, ram_addr_d;
    logic [IDX_W-1:0]     ram_rule_idx_q, ram_rule_idx_d;
    logic [NUM_CHUNK-1:0] ram_wbit_q, ram_wbit_d;
    logic                 err_q, err_d;

    logic [NUM_CHUNK-1:0] wbit_gen;
    logic                 accept;
    logic                 reject;
    logic                 last_addr;

    assign accept    = (state_q == IDLE) && upd_valid;
    assign last_addr = &ram_addr_q;

    // A power-of-two rule count cannot be exceeded by an IDX_W-bit index
    if (MAX_RULE < (1 << IDX_W)) begin : g_range
        assign reject = (idx_q >= IDX_W'(MAX_RULE));
    end else begin : g_norange
        assign reject = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (upd_valid) state_d = DRAIN;
            DRAIN:   state_d = reject ? DONE : WRITE;
            WRITE:   if (last_addr) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered RAM port; the address register doubles as the walk counter
    always_comb begin
        ram_we_d   = 1'b0;
        ram_addr_d = '0;
        err_d      = err_q;
        case (state_q)
            IDLE: err_d = 1'b0;
            DRAIN: begin
                if (reject) begin
                    err_d = 1'b1;
                end else begin
                    ram_we_d = 1'b1;
                end
            end
            WRITE: begin
                if (!last_addr) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = ram_addr_q + CHUNK_W'(1);
                end
            end
            default: ;
        endcase
        ram_rule_idx_d = ram_we_d ? idx_q : '0;
        ram_wbit_d     = ram_we_d ? wbit_gen : '0;
    end

    tcam_wbit_gen #(
        .RULE_LEN (RULE_LEN),
        .CHUNK_W  (CHUNK_W)
    ) u_wbit_gen (
        .addr  (ram_addr_d),
        .value (value_q),
        .mask  (mask_q),
        .op    (op_q),
        .wbit  (wbit_gen)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_we_q       <= 1'b0;
            ram_addr_q     <= '0;
            ram_rule_idx_q <= '0;
            ram_wbit_q     <= '0;
            err_q          <= 1'b0;
        end else begin
            ram_we_q       <= ram_we_d;
            ram_addr_q     <= ram_addr_d;
            ram_rule_idx_q <= ram_rule_idx_d;
            ram_wbit_q     <= ram_wbit_d;
            err_q          <= err_d;
        end
    end

    // Command fields only matter once accepted, so they carry no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= upd_op;
            idx_q   <= upd_rule_idx;
            value_q <= upd_value;
            mask_q  <= upd_mask;
        end
    end

    assign upd_ready    = (state_q == IDLE);
    assign search_stall = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign err          = (state_q == DONE) && err_q;
    assign ram_we       = ram_we_q;
    assign ram_addr     = ram_addr_q;
    assign ram_rule_idx = ram_rule_idx_q;
    assign ram_wbit     = ram_wbit_q;

endmodule

// File: tb/tb_tcam_update_ctrl.sv
// Directed bench for tcam_update_ctrl: install/delete walks, rejection,
// back-to-back commands, mid-update reset and the all-don't-care rule.
module tb_tcam_update_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        upd_valid, upd_valid2;
    logic        upd_op;
    logic [5:0]  upd_rule_idx;
    logic [31:0] upd_value, upd_mask;

    logic        ready, we, stall, done, err;
    logic [4:0]  addr;
    logic [5:0]  ridx;
    logic [6:0]  wbit;

    logic        ready2, we2, stall2, done2, err2;
    logic [4:0]  addr2;
    logic [5:0]  ridx2;
    logic [6:0]  wbit2;

    int n_cmp = 0;
    int n_bad = 0;
    logic [6:0] cap [32];

    always #5 clk = ~clk;

    tcam_update_ctrl #(.RULE_LEN(32), .MAX_RULE(64), .CHUNK_W(5)) dut (
        .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(ready),
        .upd_op(upd_op), .upd_rule_idx(upd_rule_idx), .upd_value(upd_value),
        .upd_mask(upd_mask), .ram_we(we), .ram_addr(addr), .ram_rule_idx(ridx),
        .ram_wbit(wbit), .search_stall(stall), .done(done), .err(err)
    );

    tcam_update_ctrl #(.RULE_LEN(32), .MAX_RULE(48), .CHUNK_W(5)) dut48 (
        .clk(clk), .rst(rst), .upd_valid(upd_valid2), .upd_ready(ready2),
        .upd_op(upd_op), .upd_rule_idx(upd_rule_idx), .upd_value(upd_value),
        .upd_mask(upd_mask), .ram_we(we2), .ram_addr(addr2), .ram_rule_idx(ridx2),
        .ram_wbit(wbit2), .search_stall(stall2), .done(done2), .err(err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bit-by-bit reference: a chunk matches when every cared key bit equals the address bit
    function automatic logic [6:0] model(input int a, input logic [31:0] v, input logic [31:0] m);
        logic [6:0] r;
        for (int c = 0; c < 7; c++) begin
            r[c] = 1'b1;
            for (int j = 0; j < 5; j++) begin
                int k;
                k = c * 5 + j;
                if (k < 32) begin
                    if (m[k] && (((a >> j) & 1) != int'(v[k]))) r[c] = 1'b0;
                end
            end
        end
        return r;
    endfunction

    task automatic run_write(input logic [5:0] idx, input logic op, input logic [31:0] v,
                             input logic [31:0] m, input bit scramble);
        for (int a = 0; a < 32; a++) begin
            step();
            chk("we", we, 1);
            chk("addr", addr, a);
            chk("ridx", ridx, idx);
            chk("stall_w", stall, 1);
            chk("done_w", done, 0);
            chk("wbit", wbit, op ? model(a, v, m) : 7'h00);
            if (op && m == 32'h0) chk("wbit_all1", wbit, 7'h7F);
            cap[a] = wbit;
            if (scramble) begin
                upd_op       = 1'($urandom);
                upd_rule_idx = 6'($urandom);
                upd_value    = $urandom;
                upd_mask     = $urandom;
            end
        end
        step();
        chk("done", done, 1);
        chk("err_ok", err, 0);
        chk("we_done", we, 0);
        chk("addr_done", addr, 0);
        chk("wbit_done", wbit, 0);
        chk("stall_done", stall, 1);
    endtask

    task automatic issue(input logic op, input logic [5:0] idx, input logic [31:0] v,
                         input logic [31:0] m);
        upd_valid    = 1'b1;
        upd_op       = op;
        upd_rule_idx = idx;
        upd_value    = v;
        upd_mask     = m;
    endtask

    initial begin
        rst = 1'b0;
        upd_valid = 1'b0; upd_valid2 = 1'b0;
        upd_op = 1'b0; upd_rule_idx = '0; upd_value = '0; upd_mask = '0;
        #2;
        chk("rst_ready", ready, 1);
        chk("rst_we", we, 0);
        chk("rst_addr", addr, 0);
        chk("rst_ridx", ridx, 0);
        chk("rst_wbit", wbit, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        #10 rst = 1'b1;
        step();

        // Install idx 3, 192.168.0.0/16
        issue(1'b1, 6'd3, 32'hC0A8_0000, 32'hFFFF_0000);
        chk("t1_ready0", ready, 1);
        step();
        upd_valid = 1'b0;
        chk("t1_stall1", stall, 1);
        chk("t1_we1", we, 0);
        chk("t1_ready1", ready, 0);
        run_write(6'd3, 1'b1, 32'hC0A8_0000, 32'hFFFF_0000, 1'b0);
        chk("t1_a0", cap[0], 7'h27);
        chk("t1_a3", cap[3], 7'h47);
        chk("t1_a10", cap[10], 7'h17);
        chk("t1_a16", cap[16], 7'h0F);
        chk("t1_a17", cap[17], 7'h0F);
        for (int a = 0; a < 32; a++) begin
            chk("t1_c3", cap[a][3], (a == 16 || a == 17) ? 1 : 0);
            chk("t1_c012", cap[a][2:0], 3'b111);
        end
        step();
        chk("t1_ready35", ready, 1);
        chk("t1_stall35", stall, 0);
        chk("t1_done35", done, 0);

        // Delete idx 63
        issue(1'b0, 6'd63, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        upd_valid = 1'b0;
        chk("t2_stall1", stall, 1);
        run_write(6'd63, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        chk("t2_stall35", stall, 0);

        // Out-of-range index on the 48-rule instance
        upd_valid2 = 1'b1; upd_op = 1'b1; upd_rule_idx = 6'd50;
        upd_value = 32'h1234_5678; upd_mask = 32'h0;
        chk("t3_ready0", ready2, 1);
        step();
        upd_valid2 = 1'b0;
        chk("t3_we1", we2, 0);
        chk("t3_done1", done2, 0);
        chk("t3_stall1", stall2, 1);
        step();
        chk("t3_done2", done2, 1);
        chk("t3_err2", err2, 1);
        chk("t3_we2", we2, 0);
        step();
        chk("t3_ready3", ready2, 1);
        chk("t3_done3", done2, 0);
        chk("t3_err3", err2, 0);
        chk("t3_we3", we2, 0);
        chk("t3_main_idle", ready, 1);

        // Back-to-back with valid held and inputs churning mid-update
        issue(1'b1, 6'd5, 32'h1234_5678, 32'h0F0F_0F0F);
        step();
        chk("t4_stall1", stall, 1);
        run_write(6'd5, 1'b1, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
        issue(1'b1, 6'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        chk("t4_ready35", ready, 1);
        step();
        upd_valid = 1'b0;
        chk("t4_accept36", ready, 0);
        chk("t4_stall36", stall, 1);
        run_write(6'd9, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("t4_a31", cap[31], 7'h7F);
        chk("t4_a3", cap[3], 7'h40);
        step();
        chk("t4_ready_end", ready, 1);

        // Reset at cycle 10 of an install, then a mask-0 install right after
        issue(1'b1, 6'd7, 32'h0, 32'h0);
        step();
        upd_valid = 1'b0;
        for (int i = 2; i <= 10; i++) step();
        chk("t5_we10", we, 1);
        chk("t5_addr10", addr, 8);
        #2 rst = 1'b0;
        #1;
        chk("t5_ready", ready, 1);
        chk("t5_we", we, 0);
        chk("t5_addr", addr, 0);
        chk("t5_ridx", ridx, 0);
        chk("t5_wbit", wbit, 0);
        chk("t5_stall", stall, 0);
        chk("t5_done", done, 0);
        chk("t5_err", err, 0);
        issue(1'b1, 6'd2, 32'hDEAD_BEEF, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        upd_valid = 1'b0;
        chk("t6_stall1", stall, 1);
        chk("t6_ready1", ready, 0);
        run_write(6'd2, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0);
        step();
        chk("t6_ready_end", ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tcam_update_ctrl.md
# tcam_update_ctrl

Rule-update sequencer for the distributed-RAM TCAM. It accepts one install or delete command per handshake and rewrites the matching rule's column in every LUTRAM chunk of the match array, walking all 2^CHUNK_W addresses. It stalls the search path for the whole update. It sits between the control-plane rule interface and the write ports of the match unit; the search datapath and priority encoder are untouched.

## Interface
- RULE_LEN, 32, key/rule width in bits
- MAX_RULE, 64, number of rule entries (rule columns)
- CHUNK_W, 5, LUTRAM address width; key bits per chunk
- IDX_W (localparam), log2(MAX_RULE), rule index width
- NUM_CHUNK (localparam), ceil(RULE_LEN/CHUNK_W) = 7 by default

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- upd_valid  in  1  command valid
- upd_ready  out  1  controller idle, command accepted on valid&ready
- upd_op  in  1  1 = install, 0 = delete
- upd_rule_idx  in  IDX_W  target rule column
- upd_value  in  RULE_LEN  rule value
- upd_mask  in  RULE_LEN  care mask, 1 = compare bit
- ram_we  out  1  write strobe to all chunk RAMs
- ram_addr  out  CHUNK_W  chunk RAM address (common to all chunks)
- ram_rule_idx  out  IDX_W  rule column written
- ram_wbit  out  NUM_CHUNK  write data, bit c for chunk c
- search_stall  out  1  match outputs invalid; search source must hold
- done  out  1  one-cycle pulse at update completion
- err  out  1  one-cycle pulse with done when the command was rejected

## Operation
- FSM states: IDLE, DRAIN, WRITE, DONE.
- IDLE: upd_ready=1. On valid&ready, register op, idx, value and mask, then go to DRAIN.
- DRAIN: one cycle, lets an in-flight search retire. If idx >= MAX_RULE, go to DONE with err set. Otherwise go to WRITE with addr counter = 0.
- WRITE: ram_we=1 and ram_addr = counter. The counter increments each cycle. When counter = 2^CHUNK_W-1, write that address, then go to DONE. The counter does not wrap back into WRITE.
- DONE: done=1 (and err if rejected) for one cycle, then IDLE.
- search_stall = 1 in DRAIN, WRITE and DONE. It is 0 in IDLE.
- Chunk c covers key bits [c*CHUNK_W +: CHUNK_W]. Bits beyond RULE_LEN in the last chunk use value=0 and mask=0 (don't care).
- Install: ram_wbit[c] = (((ram_addr ^ value_c) & mask_c) == 0).
- Delete: ram_wbit = 0 at every address.
- upd_* inputs are ignored outside IDLE. No command queueing.
- ram_* outputs are registered. They are 0 whenever ram_we=0.

## Timing
- Reset values: upd_ready=1 (state IDLE), ram_we=0, ram_addr=0, ram_rule_idx=0, ram_wbit=0, search_stall=0, done=0, err=0.
- Cycle 0: accept. Cycle 1: DRAIN. Cycles 2 to 2+2^CHUNK_W-1: writes (cycles 2–33 by default). Cycle 34: done. Cycle 35: upd_ready=1.
- Throughput is one update per 2^CHUNK_W+3 cycles. A rejected command takes 3 cycles (accept, DRAIN, DONE).
- upd_valid held high in the IDLE cycle after DONE is accepted immediately. There is no dead cycle.
- Reset mid-update aborts at once and leaves the rule column partially written. The control plane must re-issue that command. No done is issued for an aborted update.

## Structure
- Shared package tcam_pkg holds:
  - the log2 function
  - CHUNK_W default
  - NUM_CHUNK derivation
  - the state enum (IDLE/DRAIN/WRITE/DONE)
- One natural sub-module: tcam_wbit_gen. It is combinational and computes ram_wbit from address, value, mask and op across all chunks, including last-chunk padding.
- FSM, counter and output registers live in tcam_update_ctrl.

## Test plan
- Install idx 3, value 0xC0A80000, mask 0xFFFF0000 -> 32 writes with ram_rule_idx=3. ram_wbit[0..2]=1 at all addresses. ram_wbit[3]=1 only at addr 16 and 17. done at cycle 34.
- Delete idx 63 -> 32 writes with ram_wbit=0 and ram_rule_idx=63. search_stall high cycles 1–34.
- MAX_RULE=48, install idx 50 -> no ram_we ever. done and err pulse at cycle 2. upd_ready=1 at cycle 3.
- Back-to-back installs with upd_valid held high -> second accept in cycle 35. upd_* changes during cycles 1–34 have no effect on writes.
- rst low at cycle 10 of an install -> all outputs take reset values asynchronously. No done. A new command is accepted on the first clock after rst rises.
- Install mask 0 -> ram_wbit = all ones (7'h7F) at all 32 addresses.
